// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs PACK_RATIO words into one wide valid/ready word with a lane-keep mask.
// Optional FIFO_RD_PACKER_PARITY_EN adds a registered per-lane even-parity output m_parity.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                             rclk,
  input  logic                             rrst_n,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic                             rempty,
  output logic                             rinc,
  input  logic                             flush,
  output logic                             m_valid,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
`ifdef FIFO_RD_PACKER_PARITY_EN
  output logic [PACK_RATIO-1:0]            m_parity,
`endif
  input  logic                             m_ready
);

  localparam int CNT_W  = $clog2(PACK_RATIO + 1);
  localparam int WIDE_W = DATA_WIDTH * PACK_RATIO;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);

  logic [WIDE_W-1:0] acc_data, acc_data_nxt;
  logic [CNT_W-1:0]  acc_cnt, acc_cnt_nxt;
  logic              flush_pend, flush_pend_nxt;
  logic              acc_ready, xfer, pop;

  function automatic logic [PACK_RATIO-1:0] keep_mask(input logic [CNT_W-1:0] cnt);
    logic [PACK_RATIO-1:0] k;
    for (int i = 0; i < PACK_RATIO; i++) k[i] = (CNT_W'(i) < cnt);
    return k;
  endfunction

  function automatic logic [PACK_RATIO-1:0] lane_parity(input logic [WIDE_W-1:0] data,
                                                        input logic [PACK_RATIO-1:0] keep);
    logic [PACK_RATIO-1:0] p;
    for (int i = 0; i < PACK_RATIO; i++) p[i] = (^data[i*DATA_WIDTH +: DATA_WIDTH]) & keep[i];
    return p;
  endfunction

  // Accumulator / pop decision; xfer is combinational from m_ready so a full accumulator keeps popping.
  always_comb begin
    acc_ready      = (acc_cnt == FULL_CNT) | ((acc_cnt != '0) & flush_pend);
    xfer           = acc_ready & (~m_valid | m_ready);
    pop            = rrst_n & ~rempty & ((acc_cnt < FULL_CNT) | xfer);
    rinc           = pop;
    flush_pend_nxt = (flush & ((acc_cnt != '0) | pop)) | (flush_pend & ~xfer);

    acc_data_nxt = acc_data;
    acc_cnt_nxt  = acc_cnt;
    if (xfer) begin
      // The word popped during a transfer starts a fresh accumulator.
      acc_data_nxt = '0;
      acc_cnt_nxt  = '0;
      if (pop) begin
        acc_data_nxt[DATA_WIDTH-1:0] = rdata;
        acc_cnt_nxt                  = CNT_W'(1);
      end
    end else if (pop) begin
      for (int i = 0; i < PACK_RATIO; i++)
        if (CNT_W'(i) == acc_cnt) acc_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
      acc_cnt_nxt = acc_cnt + CNT_W'(1);
    end
  end

  // Accumulator and output register stage
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      acc_data   <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
`ifdef FIFO_RD_PACKER_PARITY_EN
      m_parity   <= '0;
`endif
    end else begin
      acc_data   <= acc_data_nxt;
      acc_cnt    <= acc_cnt_nxt;
      flush_pend <= flush_pend_nxt;
      if (xfer) begin
        m_valid  <= 1'b1;
        m_data   <= acc_data;
        m_keep   <= keep_mask(acc_cnt);
`ifdef FIFO_RD_PACKER_PARITY_EN
        m_parity <= lane_parity(acc_data, keep_mask(acc_cnt));
`endif
      end else if (m_ready) begin
        m_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed vector table, hand-written multi-cycle sequences, and
// randomized traffic against a queue-based reference model.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PR = 4;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic          rinc;
  logic          flush;
  logic          m_valid;
  logic [DW*PR-1:0] m_data;
  logic [PR-1:0] m_keep;
  logic          m_ready;
`ifdef FIFO_RD_PACKER_PARITY_EN
  logic [PR-1:0] m_parity;
`endif

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep),
`ifdef FIFO_RD_PACKER_PARITY_EN
    .m_parity(m_parity),
`endif
    .m_ready(m_ready)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic        rst_n, empty;
    logic [7:0]  din;
    logic        fl, rdy, e_rinc, e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
  } vec_t;

  vec_t       tv[$];
  logic [7:0] fq[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] d, input logic f,
                              input logic rdy, input logic er, input logic ev,
                              input logic [31:0] ed, input logic [3:0] ek);
    vec_t v;
    v.rst_n = r; v.empty = e; v.din = d; v.fl = f; v.rdy = rdy;
    v.e_rinc = er; v.e_valid = ev; v.e_data = ed; v.e_keep = ek;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] d, input logic f,
                       input logic rdy);
    rrst_n = r; rempty = e; rdata = d; flush = f; m_ready = rdy;
    #1;
  endtask

  task automatic q_drive(input logic r, input logic f, input logic rdy);
    drive(r, fq.size() == 0, (fq.size() == 0) ? 8'h00 : fq[0], f, rdy);
  endtask

  task automatic tick();
    if (rinc === 1'b1 && fq.size() > 0) void'(fq.pop_front());
    @(posedge rclk);
    @(negedge rclk);
  endtask

  // Reference model state: accumulated words, pending flush, output slot.
  logic [7:0]  macc[$];
  bit          mfp, mov;
  logic [31:0] mod;
  logic [3:0]  mok;

  function automatic logic [3:0] par_of(input logic [31:0] d, input logic [3:0] k);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = (^d[i*8 +: 8]) & k[i];
    return p;
  endfunction

  initial begin
    logic [31:0] got[$];
    int          pops;
    bit          m_ready_b, fl_b, rst_b, ready, xfer, pop, nfp;

    drive(1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    @(posedge rclk);
    @(negedge rclk);

    // reset
    for (int i = 0; i < 3; i++) tv.push_back(mk(0, 0, 8'h55, 0, 1, 0, 0, 32'h0, 4'h0));
    // stream 01..08
    for (int i = 1; i <= 4; i++) tv.push_back(mk(1, 0, 8'(i), 0, 1, 1, 0, 32'h0, 4'h0));
    tv.push_back(mk(1, 0, 8'h05, 0, 1, 1, 0, 32'h0, 4'h0));
    tv.push_back(mk(1, 0, 8'h06, 0, 1, 1, 1, 32'h04030201, 4'hF));
    tv.push_back(mk(1, 0, 8'h07, 0, 1, 1, 0, 32'h04030201, 4'hF));
    tv.push_back(mk(1, 0, 8'h08, 0, 1, 1, 0, 32'h04030201, 4'hF));
    tv.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 32'h04030201, 4'hF));
    tv.push_back(mk(1, 1, 8'h00, 0, 1, 0, 1, 32'h08070605, 4'hF));
    // flush with third pop, then pop during the flushed transfer
    tv.push_back(mk(1, 0, 8'hAA, 0, 1, 1, 0, 32'h08070605, 4'hF));
    tv.push_back(mk(1, 0, 8'hBB, 0, 1, 1, 0, 32'h08070605, 4'hF));
    tv.push_back(mk(1, 0, 8'hCC, 1, 1, 1, 0, 32'h08070605, 4'hF));
    tv.push_back(mk(1, 0, 8'hDD, 0, 1, 1, 0, 32'h08070605, 4'hF));
    tv.push_back(mk(1, 1, 8'h00, 0, 1, 0, 1, 32'h00CCBBAA, 4'h7));
    tv.push_back(mk(1, 1, 8'h00, 1, 1, 0, 0, 32'h00CCBBAA, 4'h7));
    tv.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 32'h00CCBBAA, 4'h7));
    tv.push_back(mk(1, 1, 8'h00, 0, 1, 0, 1, 32'h000000DD, 4'h1));
    // flush with empty accumulator and no pop is dropped
    tv.push_back(mk(1, 1, 8'h00, 1, 1, 0, 0, 32'h000000DD, 4'h1));
    tv.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 32'h000000DD, 4'h1));
    tv.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 32'h000000DD, 4'h1));

    foreach (tv[k]) begin
      drive(tv[k].rst_n, tv[k].empty, tv[k].din, tv[k].fl, tv[k].rdy);
      chk($sformatf("vec%0d_rinc", k), 64'(rinc), 64'(tv[k].e_rinc));
      chk($sformatf("vec%0d_out", k), {m_valid, m_keep, m_data}, {tv[k].e_valid, tv[k].e_keep, tv[k].e_data});
      @(posedge rclk);
      @(negedge rclk);
    end

    // back-pressure: 12 words, downstream stalled
    for (int i = 1; i <= 12; i++) fq.push_back(8'(i));
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      q_drive(1'b1, 1'b0, 1'b0);
      if (rinc === 1'b1) pops++;
      if (c == 11) begin
        chk("bp_rinc_stall", 64'(rinc), 64'd0);
        chk("bp_valid_hold", 64'(m_valid), 64'd1);
        chk("bp_data_hold", 64'(m_data), 64'h04030201);
      end
      tick();
    end
    chk("bp_pop_count", 64'(pops), 64'd8);
    got.delete();
    for (int c = 0; c < 40 && got.size() < 3; c++) begin
      q_drive(1'b1, 1'b0, 1'b1);
      if (m_valid === 1'b1) got.push_back(m_data);
      tick();
    end
    chk("bp_word_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_word0", 64'(got[0]), 64'h04030201);
      chk("bp_word1", 64'(got[1]), 64'h08070605);
      chk("bp_word2", 64'(got[2]), 64'h0C0B0A09);
    end
    chk("bp_fifo_drained", 64'(fq.size()), 64'd0);

    // reset mid-stream with a held output word and two words accumulated
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h21 + i));
    for (int c = 0; c < 6; c++) begin
      q_drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h03); fq.push_back(8'h07);
    q_drive(1'b0, 1'b0, 1'b0);
    chk("rst_mid_valid_before", 64'(m_valid), 64'd1);
    chk("rst_mid_rinc", 64'(rinc), 64'd0);
    tick();
    q_drive(1'b1, 1'b0, 1'b1);
    chk("rst_mid_cleared", {m_valid, m_keep, m_data}, 64'd0);
    got.delete();
    for (int c = 0; c < 20 && got.size() < 1; c++) begin
      if (c != 0) q_drive(1'b1, 1'b0, 1'b1);
      if (m_valid === 1'b1) begin
        got.push_back(m_data);
        chk("rst_mid_keep", 64'(m_keep), 64'hF);
`ifdef FIFO_RD_PACKER_PARITY_EN
        chk("rst_mid_parity", 64'(m_parity), 64'b1010);
`endif
      end
      tick();
    end
    chk("rst_mid_word_count", 64'(got.size()), 64'd1);
    if (got.size() == 1) chk("rst_mid_word", 64'(got[0]), 64'h07030100);

    // randomized traffic against the reference model
    q_drive(1'b0, 1'b0, 1'b0);
    tick();
    macc.delete(); mfp = 0; mov = 0; mod = '0; mok = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 16) fq.push_back(8'($urandom));
      rst_b     = ($urandom_range(0, 149) != 0);
      fl_b      = ($urandom_range(0, 7) == 0);
      m_ready_b = ($urandom_range(0, 3) != 0);

      ready = (macc.size() == PR) || (macc.size() > 0 && mfp);
      xfer  = ready && (!mov || m_ready_b);
      pop   = rst_b && fq.size() > 0 && (macc.size() < PR || xfer);

      q_drive(rst_b, fl_b, m_ready_b);
      chk($sformatf("rnd%0d_rinc", c), 64'(rinc), 64'(pop));
      chk($sformatf("rnd%0d_out", c), {m_valid, m_keep, m_data}, {mov, mok, mod});
`ifdef FIFO_RD_PACKER_PARITY_EN
      chk($sformatf("rnd%0d_parity", c), 64'(m_parity), 64'(par_of(mod, mok)));
`endif
      if (!rst_b) begin
        macc.delete(); mfp = 0; mov = 0; mod = '0; mok = '0;
      end else begin
        nfp = (fl_b && (macc.size() != 0 || pop)) || (mfp && !xfer);
        if (xfer) begin
          mov = 1;
          mod = '0;
          foreach (macc[i]) mod[i*8 +: 8] = macc[i];
          mok = 4'((1 << macc.size()) - 1);
          macc.delete();
        end else if (mov && m_ready_b) begin
          mov = 0;
        end
        if (pop) macc.push_back(fq[0]);
        mfp = nfp;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
